// File: rtl/rob_param_if.sv
// Handshake bundle between the pipeline (rename / execute / retire) and
// the reorder buffer: allocation, writeback and commit channels.
interface rob_param_if #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
);
  localparam int TAG_W = $clog2(DEPTH);

  // allocate (rename)
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_has_dst;
  logic [AREG_W-1:0] alloc_dst_arch;
  logic [PREG_W-1:0] alloc_dst_phys;
  logic [PREG_W-1:0] alloc_old_phys;
  logic [TAG_W-1:0]  alloc_tag;
  // writeback (execute)
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic              wb_exc;
  // commit (retire)
  logic              commit_valid;
  logic              commit_ready;
  logic              commit_has_dst;
  logic [AREG_W-1:0] commit_dst_arch;
  logic [PREG_W-1:0] commit_dst_phys;
  logic [PREG_W-1:0] commit_old_phys;
  logic              commit_exc;
  // status
  logic              flush;
  logic [TAG_W:0]    count;

  modport master (
    output alloc_valid, alloc_has_dst, alloc_dst_arch, alloc_dst_phys, alloc_old_phys,
    output wb_valid, wb_tag, wb_exc, commit_ready,
    input  alloc_ready, alloc_tag, commit_valid, commit_has_dst, commit_dst_arch,
    input  commit_dst_phys, commit_old_phys, commit_exc, flush, count
  );

  modport slave (
    input  alloc_valid, alloc_has_dst, alloc_dst_arch, alloc_dst_phys, alloc_old_phys,
    input  wb_valid, wb_tag, wb_exc, commit_ready,
    output alloc_ready, alloc_tag, commit_valid, commit_has_dst, commit_dst_arch,
    output commit_dst_phys, commit_old_phys, commit_exc, flush, count
  );
endinterface

// File: rtl/rob_param.sv
// Parametrised in-order reorder buffer: one allocate, out-of-order
// writeback, one in-order commit per cycle.
// Optional precise-exception flush is enabled by defining ROB_EXC_EN.

// One ROB slot: status bits with async reset, payload without reset
// (payload is only observed while the slot is valid).
module rob_param_entry #(
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_we,
  input  logic              wb_we,
  input  logic              wb_exc,
  input  logic              commit_clr,
  input  logic              flush_clr,
  input  logic              in_has_dst,
  input  logic [AREG_W-1:0] in_dst_arch,
  input  logic [PREG_W-1:0] in_dst_phys,
  input  logic [PREG_W-1:0] in_old_phys,
  output logic              done,
  output logic              exc,
  output logic              has_dst,
  output logic [AREG_W-1:0] dst_arch,
  output logic [PREG_W-1:0] dst_phys,
  output logic [PREG_W-1:0] old_phys
);
  logic valid;

  // valid/done: flush beats allocate; writeback only lands on a live slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (flush_clr) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (alloc_we) begin
      valid <= 1'b1;
      done  <= 1'b0;
    end else begin
      if (wb_we && valid) done  <= 1'b1;
      if (commit_clr)     valid <= 1'b0;
    end
  end

`ifdef ROB_EXC_EN
  // exception flag follows the same write rules as done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                exc <= 1'b0;
    else if (flush_clr)        exc <= 1'b0;
    else if (alloc_we)         exc <= 1'b0;
    else if (wb_we && valid)   exc <= wb_exc;
  end
`else
  logic unused_wb_exc;
  assign unused_wb_exc = wb_exc;
  assign exc = 1'b0;
`endif

  // payload captured at allocation
  always_ff @(posedge clk) begin
    if (alloc_we) begin
      has_dst  <= in_has_dst;
      dst_arch <= in_dst_arch;
      dst_phys <= in_dst_phys;
      old_phys <= in_old_phys;
    end
  end
endmodule

module rob_param #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  rob_param_if.slave rob
);
  localparam int TAG_W = $clog2(DEPTH);

  logic [TAG_W:0]   head_ptr, tail_ptr, count_q;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             empty, full, flush_q, exc_flush;
  logic             alloc_fire, commit_fire;

  logic [DEPTH-1:0]             e_done, e_exc, e_has_dst;
  logic [DEPTH-1:0][AREG_W-1:0] e_dst_arch;
  logic [DEPTH-1:0][PREG_W-1:0] e_dst_phys, e_old_phys;

  assign head_idx = head_ptr[TAG_W-1:0];
  assign tail_idx = tail_ptr[TAG_W-1:0];
  assign empty    = (head_ptr == tail_ptr);
  assign full     = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);

  // no same-cycle bypass: a full ROB stays closed even while committing
  assign rob.alloc_ready  = !full && !flush_q;
  assign rob.alloc_tag    = tail_idx;
  assign rob.commit_valid = !empty && e_done[head_idx] && !flush_q;
  assign alloc_fire       = rob.alloc_valid && rob.alloc_ready;
  assign commit_fire      = rob.commit_valid && rob.commit_ready;

  assign rob.commit_has_dst  = e_has_dst[head_idx];
  assign rob.commit_dst_arch = e_dst_arch[head_idx];
  assign rob.commit_dst_phys = e_dst_phys[head_idx];
  assign rob.commit_old_phys = e_old_phys[head_idx];
  assign rob.count           = count_q;
  assign rob.flush           = flush_q;

`ifdef ROB_EXC_EN
  assign rob.commit_exc = e_exc[head_idx];
  assign exc_flush      = commit_fire && e_exc[head_idx];

  // flush is a one-cycle pulse following the excepting commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_q <= 1'b0;
    else        flush_q <= exc_flush;
  end
`else
  logic unused_exc;
  assign unused_exc     = ^e_exc;
  assign rob.commit_exc = 1'b0;
  assign exc_flush      = 1'b0;
  assign flush_q        = 1'b0;
`endif

  // pointers and occupancy; an exception commit rewinds everything to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (exc_flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (commit_fire) head_ptr <= head_ptr + (TAG_W+1)'(1);
      if (alloc_fire)  tail_ptr <= tail_ptr + (TAG_W+1)'(1);
      count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rob_param_entry #(.PREG_W(PREG_W), .AREG_W(AREG_W)) u_ent (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc_we    (alloc_fire && (tail_idx == TAG_W'(i))),
      .wb_we       (rob.wb_valid && (rob.wb_tag == TAG_W'(i))),
      .wb_exc      (rob.wb_exc),
      .commit_clr  (commit_fire && (head_idx == TAG_W'(i))),
      .flush_clr   (exc_flush),
      .in_has_dst  (rob.alloc_has_dst),
      .in_dst_arch (rob.alloc_dst_arch),
      .in_dst_phys (rob.alloc_dst_phys),
      .in_old_phys (rob.alloc_old_phys),
      .done        (e_done[i]),
      .exc         (e_exc[i]),
      .has_dst     (e_has_dst[i]),
      .dst_arch    (e_dst_arch[i]),
      .dst_phys    (e_dst_phys[i]),
      .old_phys    (e_old_phys[i])
    );
  end
endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param (DEPTH=16): vector table plus hand-written
// sequences for full/wrap, streaming, exception flush and async reset.
module tb_rob_param;
  localparam int DEPTH = 16, PREG_W = 6, AREG_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_param_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W)) rif ();
  rob_param #(.DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
    .clk(clk), .rst_n(rst_n), .rob(rif)
  );

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    logic       av;  logic [5:0] ph;
    logic       wv;  logic [3:0] wt;
    logic       cr;
    logic       e_rdy; logic [3:0] e_tag; logic e_cv; logic [5:0] e_ph; logic [4:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input int av, ph, wv, wt, cr, rdy, tag, cv, eph, cnt);
    vec_t v;
    v.av = 1'(av); v.ph = 6'(ph); v.wv = 1'(wv); v.wt = 4'(wt); v.cr = 1'(cr);
    v.e_rdy = 1'(rdy); v.e_tag = 4'(tag); v.e_cv = 1'(cv); v.e_ph = 6'(eph); v.e_cnt = 5'(cnt);
    return v;
  endfunction

  task automatic drive(input logic av, input logic [5:0] ph, input logic wv,
                       input logic [3:0] wt, input logic we, input logic cr);
    rif.alloc_valid    = av;
    rif.alloc_has_dst  = 1'b1;
    rif.alloc_dst_phys = ph;
    rif.alloc_dst_arch = ph[4:0];
    rif.alloc_old_phys = ~ph;
    rif.wb_valid       = wv;
    rif.wb_tag         = wt;
    rif.wb_exc         = we;
    rif.commit_ready   = cr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  vec_t vt[13];

  initial begin
    logic [5:0] exp_old;
    int sent, got, ptag;
    logic pend;

    // rows: alloc, phys, wb, wb_tag, commit_ready | rdy, tag, cv, phys, count
    vt[0]  = mk(1, 10, 0, 0, 0,  1, 0, 0,  0, 0);
    vt[1]  = mk(1, 11, 0, 0, 0,  1, 1, 0,  0, 1);
    vt[2]  = mk(0,  0, 1, 1, 0,  1, 2, 0,  0, 2);  // younger completes first
    vt[3]  = mk(0,  0, 1, 0, 1,  1, 2, 0,  0, 2);  // head not yet done
    vt[4]  = mk(0,  0, 0, 0, 1,  1, 2, 1, 10, 2);
    vt[5]  = mk(0,  0, 0, 0, 1,  1, 2, 1, 11, 1);
    vt[6]  = mk(0,  0, 1, 5, 1,  1, 2, 0,  0, 0);  // wb to free slot
    vt[7]  = mk(1, 20, 0, 0, 1,  1, 2, 0,  0, 0);
    vt[8]  = mk(0,  0, 1, 2, 1,  1, 3, 0,  0, 1);
    vt[9]  = mk(0,  0, 1, 2, 0,  1, 3, 1, 20, 1);  // duplicate wb, retire stalls
    vt[10] = mk(0,  0, 0, 0, 1,  1, 3, 1, 20, 1);
    vt[11] = mk(1, 21, 0, 0, 1,  1, 3, 0,  0, 0);
    vt[12] = mk(0,  0, 0, 0, 0,  1, 4, 0,  0, 1);

    // reset state, sampled while reset is held
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_count", int'(rif.count), 0);
    chk("rst_alloc_ready", int'(rif.alloc_ready), 1);
    chk("rst_commit_valid", int'(rif.commit_valid), 0);
    chk("rst_alloc_tag", int'(rif.alloc_tag), 0);
    chk("rst_flush", int'(rif.flush), 0);
    rst_n = 1'b1;

    // table-driven basic alloc / out-of-order wb / in-order commit
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].av, vt[i].ph, vt[i].wv, vt[i].wt, 1'b0, vt[i].cr);
      chk($sformatf("vec%0d_ready", i), int'(rif.alloc_ready), int'(vt[i].e_rdy));
      chk($sformatf("vec%0d_tag", i), int'(rif.alloc_tag), int'(vt[i].e_tag));
      chk($sformatf("vec%0d_cv", i), int'(rif.commit_valid), int'(vt[i].e_cv));
      chk($sformatf("vec%0d_count", i), int'(rif.count), int'(vt[i].e_cnt));
      if (vt[i].e_cv) begin
        exp_old = ~vt[i].e_ph;
        chk($sformatf("vec%0d_phys", i), int'(rif.commit_dst_phys), int'(vt[i].e_ph));
        chk($sformatf("vec%0d_old", i), int'(rif.commit_old_phys), int'(exp_old));
        chk($sformatf("vec%0d_arch", i), int'(rif.commit_dst_arch), int'(vt[i].e_ph[4:0]));
      end
      tick();
    end

    // fill to DEPTH, then commit with alloc held: no bypass, tag wraps to 0
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 6'(30 + i), 0, 0, 0, 0);
      tick();
    end
    drive(1, 50, 1, 0, 0, 1);
    chk("full_count", int'(rif.count), 16);
    chk("full_ready", int'(rif.alloc_ready), 0);
    chk("full_cv_before_wb", int'(rif.commit_valid), 0);
    tick();
    drive(1, 50, 0, 0, 0, 1);
    chk("full_commit_cv", int'(rif.commit_valid), 1);
    chk("full_commit_phys", int'(rif.commit_dst_phys), 30);
    chk("full_no_bypass", int'(rif.alloc_ready), 0);
    tick();
    chk("full_after_commit_ready", int'(rif.alloc_ready), 1);
    chk("full_after_commit_tag", int'(rif.alloc_tag), 0);
    chk("full_after_commit_count", int'(rif.count), 15);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("refill_count", int'(rif.count), 16);
    chk("refill_tag", int'(rif.alloc_tag), 1);
    chk("refill_ready", int'(rif.alloc_ready), 0);

    // stream 40 instructions, wb one cycle after alloc, commit always ready
    do_reset();
    sent = 0; got = 0; pend = 1'b0; ptag = 0;
    for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
      drive(sent < 40, 6'(sent), pend, 4'(ptag), 0, 1);
      if (rif.commit_valid) begin
        chk($sformatf("stream_commit%0d", got), int'(rif.commit_dst_phys), got);
        got++;
      end
      if (rif.alloc_valid && rif.alloc_ready) begin
        ptag = int'(rif.alloc_tag); pend = 1'b1; sent++;
      end else pend = 1'b0;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("stream_total", got, 40);
    chk("stream_drain_count", int'(rif.count), 0);
    chk("stream_tail_wrap", int'(rif.alloc_tag), 40 % DEPTH);

    // excepting instruction reaches the head
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'(40 + i), 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0, 1, 0);
    tick();
    drive(1, 60, 0, 0, 0, 1);
    chk("exc_cv", int'(rif.commit_valid), 1);
    chk("exc_count_pre", int'(rif.count), 3);
`ifdef ROB_EXC_EN
    chk("exc_commit_exc", int'(rif.commit_exc), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("exc_flush", int'(rif.flush), 1);
    chk("exc_flush_ready", int'(rif.alloc_ready), 0);
    chk("exc_flush_cv", int'(rif.commit_valid), 0);
    chk("exc_flush_count", int'(rif.count), 0);
    chk("exc_flush_tag", int'(rif.alloc_tag), 0);
    tick();
    chk("exc_flush_end", int'(rif.flush), 0);
    chk("exc_ready_back", int'(rif.alloc_ready), 1);
`else
    chk("noexc_commit_exc", int'(rif.commit_exc), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("noexc_flush", int'(rif.flush), 0);
    chk("noexc_count", int'(rif.count), 3);
    chk("noexc_tag", int'(rif.alloc_tag), 4);
`endif

    // async reset mid-cycle with 5 entries live
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 6'(1 + i), 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("mid_count_pre", int'(rif.count), 5);
    chk("mid_cv_pre", int'(rif.commit_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", int'(rif.count), 0);
    chk("mid_rst_cv", int'(rif.commit_valid), 0);
    chk("mid_rst_ready", int'(rif.alloc_ready), 1);
    chk("mid_rst_tag", int'(rif.alloc_tag), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", int'(rif.count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rob_param.md
# rob_param

Parametrised in-order reorder buffer: the next generation of the single-push/single-pop ROB. It allocates one entry per cycle at rename, accepts out-of-order completion from execute writeback, and retires one completed entry per cycle from the head in program order. It sits between rename/dispatch and the physical register file free list. Optional precise-exception support (`ROB_EXC_EN`) flushes the buffer when an excepting instruction reaches the head.

## Interface
Parameters:
- `DEPTH`, default 16: number of entries; a power of 2, at least 4.
- `PREG_W`, default 6: physical register tag width.
- `AREG_W`, default 5: architectural register index width.

Derived: `TAG_W = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alloc_valid`  in  1  rename presents a new instruction.
- `alloc_ready`  out  1  an entry is free; allocation occurs on `alloc_valid && alloc_ready`.
- `alloc_has_dst`  in  1  the instruction writes a register.
- `alloc_dst_arch`  in  AREG_W  destination architectural register.
- `alloc_dst_phys`  in  PREG_W  newly mapped physical register.
- `alloc_old_phys`  in  PREG_W  previous mapping, freed at commit.
- `alloc_tag`  out  TAG_W  index of the entry being allocated (the tail).
- `wb_valid`  in  1  an execute unit has completed an instruction.
- `wb_tag`  in  TAG_W  ROB index of the completed instruction.
- `wb_exc`  in  1  the completed instruction raised an exception (used only with `ROB_EXC_EN`).
- `commit_valid`  out  1  the head entry is complete.
- `commit_ready`  in  1  the retire stage accepts; commit occurs on `commit_valid && commit_ready`.
- `commit_has_dst`, `commit_dst_arch`, `commit_dst_phys`, `commit_old_phys`  out  1/AREG_W/PREG_W/PREG_W  fields of the head entry.
- `commit_exc`  out  1  the head entry carries an exception.
- `flush`  out  1  one-cycle pulse; the ROB was cleared.
- `count`  out  TAG_W+1  number of occupied entries, 0..DEPTH.

## Operation
- Each entry holds: `valid`, `done`, `exc`, `has_dst`, `dst_arch`, `dst_phys`, `old_phys`.
- `head_ptr` and `tail_ptr` are TAG_W+1 bits wide; the MSB is a wrap bit, and the low TAG_W bits index the entry array.
  - Empty: the pointers are equal.
  - Full: the low bits are equal and the MSBs differ.
- Allocate: write all fields into the tail entry with `valid=1`, `done=0`, `exc=0`, then increment `tail_ptr`.
- Writeback: if the addressed entry has `valid=1`, set `done=1` and set `exc=wb_exc`. A writeback to an entry with `valid=0` is ignored. A duplicate writeback is idempotent.
- Commit: clear the head entry's `valid` and increment `head_ptr`.
- `count` is updated as `+alloc −commit` each cycle. Simultaneous allocate and commit leaves it unchanged.
- `alloc_ready = !full && !flush`. There is no same-cycle bypass: a full ROB refuses allocation even when a commit happens in the same cycle.
- `commit_valid = !empty && head.done && !flush`.
- `alloc_tag` and the `commit_*` fields are combinational from the pointers and the entry array.
- Writeback and allocation to the same index in one cycle cannot occur, because the entry would have to be both valid and free.

## Timing
- Reset (async assert, sync-style deassert at a clock edge):
  - pointers = 0, `count` = 0, all `valid`/`done`/`exc` bits = 0, `flush` = 0.
  - Hence `alloc_ready` = 1, `commit_valid` = 0, `alloc_tag` = 0.
- Writeback at edge N sets `done` at N. The earliest commit of that entry is the cycle after edge N (one-cycle writeback-to-commit latency).
- Alloc-to-commit minimum latency is 2 cycles: allocate at edge N, writeback in the cycle after N, commit in the cycle after that.
- Reset asserted mid-operation discards all entries immediately. Retire must not sample `commit_*` while `rst_n` = 0.
- Pointers wrap naturally modulo 2·DEPTH. Correct full/empty detection across wrap is mandatory.

## Configuration
- `ROB_EXC_EN` defined:
  - `wb_exc` is stored in the entry and `commit_exc` reflects the head entry's `exc`.
  - A commit handshake with `commit_exc=1` clears every `valid`, sets both pointers to 0 and `count` to 0 at that edge, and registers `flush=1` for exactly the next cycle.
  - An allocation accepted in that same handshake cycle is discarded.
  - While `flush=1`, `alloc_ready` and `commit_valid` are 0.
- `ROB_EXC_EN` undefined:
  - `wb_exc` is ignored, and `exc` storage is removed.
  - `commit_exc` and `flush` are tied to 0.

## Test plan
- Reset, then allocate phys 10 then 11 with no writebacks: expect `alloc_tag` 0 then 1, `count`=2, `commit_valid`=0 throughout.
- Writeback tag 1, then writeback tag 0: expect no commit after the first writeback, then commit of phys 10 followed by commit of phys 11 on consecutive cycles in program order.
- Fill to DEPTH=16 entries: expect `alloc_ready`=0 at `count`=16. Writeback the head and commit with `alloc_valid`=1 held: the allocation is accepted only in the cycle after the commit, and `alloc_tag`=0 (wrap).
- Stream 40 instructions with single-cycle writeback and `commit_ready`=1: commits are in order with no loss, and the pointers wrap twice.
- With `ROB_EXC_EN`: allocate 3 entries, writeback tag 0 with `wb_exc`=1, commit it: `commit_exc`=1, `flush`=1 in the next cycle, then `count`=0 and `alloc_tag`=0.
- Assert `rst_n`=0 mid-cycle while `count`=5: outputs return to their reset values immediately, without waiting for a clock edge.
